// File: rtl/edge_event_scheduler.sv
// Round-robin scheduler that shares one single-bit cross-domain pulse channel
// (edge propagator TX side) between NumSrc requesters in the TX clock domain.
//
// Each requester pulse is captured as a pending flag. Pending flags are granted
// round-robin. Every grant issues a one-cycle edge pulse and a stable source id,
// then waits for the synchronized acknowledge (or a timeout), then holds off for
// GapCycles idle cycles before the next grant can be made.
//
// Ports:
//   clk_i        TX-domain clock, rising edge
//   rst_i        asynchronous reset, active-high
//   en_i         allow new grants; in-flight events always complete
//   src_pulse_i  one-cycle event requests, one bit per source
//   ovf_clr_i    clears matching ovf_o bits (a same-cycle overflow set wins)
//   ack_i        synchronized acknowledge returned from the channel
//   edge_o       one-cycle registered pulse into the shared channel
//   id_o         granted source index, stable from issue until the next issue
//   pend_o       pending flags
//   ovf_o        sticky overflow flags
//   busy_o       high whenever the scheduler is not idle
//   timeout_o    sticky ack-timeout flag, cleared only by reset
module edge_event_scheduler #(
  parameter int unsigned NumSrc     = 4,
  parameter int unsigned IdWidth    = (NumSrc > 1) ? $clog2(NumSrc) : 1,
  parameter int unsigned GapCycles  = 2,
  parameter int unsigned AckTimeout = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NumSrc-1:0]  src_pulse_i,
  input  logic [NumSrc-1:0]  ovf_clr_i,
  input  logic               ack_i,
  output logic               edge_o,
  output logic [IdWidth-1:0] id_o,
  output logic [NumSrc-1:0]  pend_o,
  output logic [NumSrc-1:0]  ovf_o,
  output logic               busy_o,
  output logic               timeout_o
);

  // Counters only ever hold 0 .. limit-1.
  localparam int unsigned AckCntW = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
  localparam int unsigned GapCntW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

  localparam logic [AckCntW-1:0] AckLast = AckCntW'(AckTimeout - 1);
  // Unused when GapCycles == 0 (the GAP state is then never entered).
  localparam logic [GapCntW-1:0] GapLast = GapCntW'(GapCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StGap
  } state_e;

  // State after an event resolves (ack or timeout).
  localparam state_e StAfterEvent = (GapCycles == 0) ? StIdle : StGap;

  state_e               state_q, state_d;
  logic                 edge_q, edge_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [NumSrc-1:0]    pend_q, pend_d;
  logic [NumSrc-1:0]    ovf_q, ovf_d;
  logic                 timeout_q, timeout_d;
  logic [AckCntW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [GapCntW-1:0]   gap_cnt_q, gap_cnt_d;

  logic                 found;
  logic [IdWidth-1:0]   winner;
  logic                 grant;
  logic [NumSrc-1:0]    grant_mask;

  // Round-robin search: first pending bit strictly after ptr_q, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= int'(NumSrc); i++) begin
      idx = (int'(ptr_q) + i) % int'(NumSrc);
      if (!found && pend_q[idx]) begin
        found  = 1'b1;
        winner = IdWidth'(idx);
      end
    end
  end

  assign grant = (state_q == StIdle) && en_i && found;

  always_comb begin
    grant_mask = '0;
    if (grant) begin
      grant_mask[winner] = 1'b1;
    end
  end

  // Pending and overflow flags. A pulse on the granted source re-arms its flag
  // without counting as an overflow, because the old event is leaving now.
  always_comb begin
    pend_d = (pend_q & ~grant_mask) | src_pulse_i;
    ovf_d  = (ovf_q & ~ovf_clr_i) | (src_pulse_i & pend_q & ~grant_mask);
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    edge_d    = 1'b0;
    id_d      = id_q;
    ptr_d     = ptr_q;
    timeout_d = timeout_q;
    ack_cnt_d = ack_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      StIdle: begin
        if (grant) begin
          id_d    = winner;
          ptr_d   = winner;
          edge_d  = 1'b1;
          state_d = StIssue;
        end
      end

      // ack_i is deliberately ignored here: it cannot belong to this event yet.
      StIssue: begin
        ack_cnt_d = '0;
        state_d   = StWaitAck;
      end

      StWaitAck: begin
        if (ack_i) begin
          gap_cnt_d = '0;
          state_d   = StAfterEvent;
        end else if (ack_cnt_q == AckLast) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = StAfterEvent;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      edge_q    <= 1'b0;
      id_q      <= '0;
      // Start just below source 0 so source 0 wins the first arbitration.
      ptr_q     <= IdWidth'(NumSrc - 1);
      pend_q    <= '0;
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign edge_o    = edge_q;
  assign id_o      = id_q;
  assign pend_o    = pend_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q != StIdle);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Testbench for edge_event_scheduler: directed scenarios plus a randomized run
// checked against a timestamp-based reference model.
module tb_edge_event_scheduler;

  localparam int NumSrc     = 4;
  localparam int IdWidth    = 2;
  localparam int GapCycles  = 2;
  localparam int AckTimeout = 16;

  logic               clk;
  logic               rst;
  logic               en;
  logic [NumSrc-1:0]  src_pulse;
  logic [NumSrc-1:0]  ovf_clr;
  logic               ack;
  logic               edge_o;
  logic [IdWidth-1:0] id_o;
  logic [NumSrc-1:0]  pend_o;
  logic [NumSrc-1:0]  ovf_o;
  logic               busy_o;
  logic               timeout_o;

  int vectors;
  int miscompares;

  edge_event_scheduler #(
    .NumSrc    (NumSrc),
    .GapCycles (GapCycles),
    .AckTimeout(AckTimeout)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .src_pulse_i(src_pulse),
    .ovf_clr_i  (ovf_clr),
    .ack_i      (ack),
    .edge_o     (edge_o),
    .id_o       (id_o),
    .pend_o     (pend_o),
    .ovf_o      (ovf_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: events are tracked by edge timestamps, not by state.
  int              cyc;
  logic [NumSrc-1:0] m_pend;
  logic [NumSrc-1:0] m_ovf;
  int              m_ptr;
  int              m_id;
  bit              m_timeout;
  int              m_g;          // edge at which the current event was granted
  bit              m_resolved;   // current event acked or timed out
  int              m_idle_edge;  // edge after which the scheduler is idle
  bit              exp_edge;
  bit              exp_busy;

  task automatic model_reset();
    m_pend      = '0;
    m_ovf       = '0;
    m_ptr       = NumSrc - 1;
    m_id        = 0;
    m_timeout   = 1'b0;
    m_g         = -100;
    m_resolved  = 1'b1;
    m_idle_edge = cyc;
    exp_edge    = 1'b0;
    exp_busy    = 1'b0;
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs settle #1 later.
  task automatic tick();
    int k;
    bit free;
    logic [NumSrc-1:0] gmask;
    @(posedge clk);
    cyc++;
    k     = -1;
    gmask = '0;
    free  = m_resolved && (cyc > m_idle_edge);
    if (free && en && (m_pend != '0)) begin
      for (int i = 1; i <= NumSrc; i++) begin
        int idx;
        idx = (m_ptr + i) % NumSrc;
        if (k < 0 && m_pend[idx]) k = idx;
      end
    end
    if (!m_resolved && cyc >= m_g + 2) begin
      if (ack) begin
        m_resolved  = 1'b1;
        m_idle_edge = cyc + GapCycles;
      end else if (cyc == m_g + 1 + AckTimeout) begin
        m_timeout   = 1'b1;
        m_resolved  = 1'b1;
        m_idle_edge = cyc + GapCycles;
      end
    end
    if (k >= 0) gmask[k] = 1'b1;
    m_ovf  = (m_ovf & ~ovf_clr) | (src_pulse & m_pend & ~gmask);
    m_pend = (m_pend & ~gmask) | src_pulse;
    if (k >= 0) begin
      m_id       = k;
      m_ptr      = k;
      m_g        = cyc;
      m_resolved = 1'b0;
    end
    exp_edge = (m_g == cyc);
    exp_busy = !(m_resolved && cyc >= m_idle_edge);
    #1;
    src_pulse = '0;
    ovf_clr   = '0;
  endtask

  // Called one time unit after a rising edge; returns at the same clock phase + 3.
  task automatic do_reset();
    en        = 1'b0;
    src_pulse = '0;
    ovf_clr   = '0;
    ack       = 1'b0;
    rst       = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0; src_pulse = '0; ovf_clr = '0; ack = 1'b0;
    #3;
    vectors++;
    if ({edge_o, busy_o, timeout_o, id_o, pend_o, ovf_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got edge=%b busy=%b to=%b id=%0d pend=%b ovf=%b want all 0",
               edge_o, busy_o, timeout_o, id_o, pend_o, ovf_o);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_event();
    int busy_cycles;
    int edge_cycles;
    do_reset();
    en = 1'b1;
    src_pulse = 4'b0100;
    tick();
    vectors++;
    if (pend_o !== 4'b0100 || edge_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_capture got pend=%b edge=%b want pend=0100 edge=0", pend_o, edge_o);
    end
    tick();
    vectors++;
    if (edge_o !== 1'b1 || id_o !== 2'd2 || pend_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_issue got edge=%b id=%0d pend=%b want edge=1 id=2 pend=0000",
               edge_o, id_o, pend_o);
    end
    ack = 1'b1;
    busy_cycles = 0;
    edge_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy_o) busy_cycles++;
      if (edge_o) edge_cycles++;
      tick();
    end
    ack = 1'b0;
    vectors++;
    if (busy_cycles !== 2 + GapCycles) begin
      miscompares++;
      $display("FAIL single_busy_len got %0d want %0d", busy_cycles, 2 + GapCycles);
    end
    vectors++;
    if (edge_cycles !== 1) begin
      miscompares++;
      $display("FAIL single_edge_len got %0d want 1", edge_cycles);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int when[$];
    do_reset();
    en = 1'b1;
    ack = 1'b1;
    src_pulse = 4'b1111;
    tick();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (edge_o) begin
        ids.push_back(int'(id_o));
        when.push_back(c);
      end
    end
    ack = 1'b0;
    vectors++;
    if (ids.size() !== 4) begin
      miscompares++;
      $display("FAIL rr_count got %0d want 4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (ids[k] !== k) begin
          miscompares++;
          $display("FAIL rr_order slot=%0d got id=%0d want id=%0d", k, ids[k], k);
        end
        if (k > 0) begin
          vectors++;
          if (when[k] - when[k-1] !== 3 + GapCycles) begin
            miscompares++;
            $display("FAIL rr_spacing slot=%0d got %0d want %0d", k, when[k] - when[k-1],
                     3 + GapCycles);
          end
        end
      end
    end
    vectors++;
    if (ovf_o !== 4'b0000 || pend_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL rr_flags got ovf=%b pend=%b want 0000 0000", ovf_o, pend_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b0;
    src_pulse = 4'b0010;
    tick();
    src_pulse = 4'b0010;
    tick();
    vectors++;
    if (ovf_o !== 4'b0010 || pend_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL ovf_set got ovf=%b pend=%b want 0010 0010", ovf_o, pend_o);
    end
    ovf_clr = 4'b0010;
    tick();
    vectors++;
    if (ovf_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL ovf_clear got %b want 0000", ovf_o);
    end
    src_pulse = 4'b0010;
    ovf_clr   = 4'b0010;
    tick();
    vectors++;
    if (ovf_o[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins got %b want 1", ovf_o[1]);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_en_blocks got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1;
    src_pulse = 4'b0001;
    tick();
    tick();  // grant
    tick();  // enter WAIT_ACK
    for (int c = 0; c < AckTimeout - 1; c++) tick();
    vectors++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early got to=%b busy=%b want to=0 busy=1", timeout_o, busy_o);
    end
    tick();
    vectors++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL to_rise got to=%b busy=%b want to=1 busy=1", timeout_o, busy_o);
    end
    for (int c = 0; c < GapCycles; c++) tick();
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL to_back_idle got busy=%b want 0", busy_o);
    end
    src_pulse = 4'b0010;
    tick();
    tick();
    vectors++;
    if (edge_o !== 1'b1 || id_o !== 2'd1 || timeout_o !== 1'b1) begin
      miscompares++;
      $display("FAIL to_next_event got edge=%b id=%0d to=%b want edge=1 id=1 to=1",
               edge_o, id_o, timeout_o);
    end
    // Ack arriving on the last allowed cycle wins over the timeout.
    do_reset();
    en = 1'b1;
    src_pulse = 4'b0001;
    tick();
    tick();
    tick();
    for (int c = 0; c < AckTimeout - 1; c++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL to_last_ack got to=%b busy=%b want to=0 busy=1", timeout_o, busy_o);
    end
  endtask

  task automatic test_same_cycle();
    int ids[$];
    do_reset();
    en = 1'b0;
    src_pulse = 4'b1000;
    tick();
    en = 1'b1;
    src_pulse = 4'b1011;
    tick();  // source 3 granted on this edge while pulsing again
    vectors++;
    if (edge_o !== 1'b1 || id_o !== 2'd3 || pend_o !== 4'b1011 || ovf_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL same_cycle_grant got edge=%b id=%0d pend=%b ovf=%b want 1 3 1011 0000",
               edge_o, id_o, pend_o, ovf_o);
    end
    ack = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (edge_o) ids.push_back(int'(id_o));
    end
    ack = 1'b0;
    vectors++;
    if (ids.size() !== 3) begin
      miscompares++;
      $display("FAIL same_cycle_count got %0d want 3", ids.size());
    end else begin
      vectors++;
      if (ids[0] !== 0 || ids[1] !== 1 || ids[2] !== 3) begin
        miscompares++;
        $display("FAIL same_cycle_order got %0d,%0d,%0d want 0,1,3", ids[0], ids[1], ids[2]);
      end
    end
  endtask

  task automatic test_reset_mid_event();
    do_reset();
    en = 1'b0;
    src_pulse = 4'b1011;
    tick();
    en = 1'b1;
    tick();  // grant source 0
    tick();  // WAIT_ACK
    vectors++;
    if (pend_o !== 4'b1010 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup got pend=%b busy=%b want 1010 1", pend_o, busy_o);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({edge_o, busy_o, pend_o, id_o, ovf_o, timeout_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_async_reset got edge=%b busy=%b pend=%b id=%0d want all 0",
               edge_o, busy_o, pend_o, id_o);
    end
    rst = 1'b0;
    model_reset();
    en = 1'b1;
    src_pulse = 4'b1010;
    tick();
    tick();
    vectors++;
    if (edge_o !== 1'b1 || id_o !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_first_grant got edge=%b id=%0d want edge=1 id=1", edge_o, id_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      en        = ($urandom_range(0, 9) != 0);
      src_pulse = ($urandom_range(0, 2) == 0) ? NumSrc'($urandom) : '0;
      ovf_clr   = ($urandom_range(0, 11) == 0) ? NumSrc'($urandom) : '0;
      // Stretches of withheld acks provoke timeouts.
      ack       = (((i / 60) % 3) == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      tick();
      vectors++;
      if (edge_o !== exp_edge) begin
        miscompares++;
        $display("FAIL rand_edge i=%0d got %b want %b", i, edge_o, exp_edge);
      end
      vectors++;
      if (busy_o !== exp_busy) begin
        miscompares++;
        $display("FAIL rand_busy i=%0d got %b want %b", i, busy_o, exp_busy);
      end
      vectors++;
      if (id_o !== IdWidth'(m_id)) begin
        miscompares++;
        $display("FAIL rand_id i=%0d got %0d want %0d", i, id_o, m_id);
      end
      vectors++;
      if (pend_o !== m_pend) begin
        miscompares++;
        $display("FAIL rand_pend i=%0d got %b want %b", i, pend_o, m_pend);
      end
      vectors++;
      if (ovf_o !== m_ovf) begin
        miscompares++;
        $display("FAIL rand_ovf i=%0d got %b want %b", i, ovf_o, m_ovf);
      end
      vectors++;
      if (timeout_o !== m_timeout) begin
        miscompares++;
        $display("FAIL rand_timeout i=%0d got %b want %b", i, timeout_o, m_timeout);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    en          = 1'b0;
    src_pulse   = '0;
    ovf_clr     = '0;
    ack         = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_event();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_same_cycle();
    test_reset_mid_event();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Shares one single-bit cross-domain pulse channel (edge propagator TX side) between NumSrc requesters in the TX clock domain.
- Captures each requester's pulse as a pending flag and grants pending flags round-robin.
- For each grant, issues one edge pulse plus a stable source id, waits for the channel's synchronized acknowledge (or a timeout), then enforces an inter-event gap before the next issue.
- Flags overflow when a requester pulses again before its previous event was issued.

Parameters:
- NumSrc, 4, number of requesters (>=1).
- IdWidth, (NumSrc>1 ? $clog2(NumSrc) : 1), width of id_o (derived; do not override).
- GapCycles, 2, idle cycles forced after each completed or timed-out event (0 allowed).
- AckTimeout, 16, max cycles waited in WAIT_ACK before abandoning (>=1).

Ports:
- clk_i  in  1  TX-domain clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  allow new issues; low blocks new grants only.
- src_pulse_i  in  NumSrc  one-cycle event requests, one bit per source.
- ovf_clr_i  in  NumSrc  clears matching ovf_o bits.
- ack_i  in  1  synchronized acknowledge returned from the channel.
- edge_o  out  1  one-cycle pulse into the shared channel.
- id_o  out  IdWidth  granted source index; stable from issue until next issue.
- pend_o  out  NumSrc  pending flags.
- ovf_o  out  NumSrc  sticky overflow flags.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  sticky; set on ack timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; edge_o=0; id_o=0; pend_o=0; ovf_o=0; busy_o=0; timeout_o=0; RR pointer = NumSrc-1, so source 0 has highest priority first.
- Pending flags:
  - A src_pulse_i[k] bit sets pend[k] at the clock edge.
  - Pulse while pend[k]=1 and k not being granted that cycle: set ovf[k]; pend stays 1.
  - Pulse in the same cycle k is granted: pend[k] stays 1 (new event captured, no overflow).
  - ovf_clr_i[k] and an overflowing pulse in the same cycle: set wins.
- States: IDLE, ISSUE, WAIT_ACK, GAP.
  - IDLE: if en_i=1 and pend!=0, pick the first set bit searching upward from ptr+1 (wrapping). At the edge: id_o<=winner, ptr<=winner, pend[winner] cleared, edge_o<=1, go to ISSUE.
  - ISSUE: lasts exactly one cycle with edge_o=1. At the edge: edge_o<=0, timeout counter<=0, go to WAIT_ACK. ack_i is ignored in ISSUE.
  - WAIT_ACK: ack_i=1 goes to GAP (or IDLE if GapCycles=0). Otherwise the counter increments; when counter==AckTimeout-1 and ack_i=0, set timeout_o and go to GAP/IDLE. If ack_i arrives on the timeout cycle, it counts as ack and timeout_o is not set.
  - GAP: counts GapCycles cycles, then returns to IDLE.
- Latency: pulse sampled at edge n gives pend_o=1 after edge n. With the scheduler IDLE and en_i=1, edge_o is high during the cycle after edge n+1.
- Minimum event spacing with immediate ack is 2+GapCycles+1 cycles between edge_o pulses. Example: GapCycles=2 gives 5 cycles.
- en_i deassertion: an in-flight event completes normally; no new grant while en_i=0; pending flags keep accumulating.
- edge_o is a direct register output, never combinational. busy_o is decoded from the state register.
- Reset asserted mid-event: everything returns to reset values immediately; pending events are lost.
- NumSrc=1: id_o is always 0 and RR degenerates to a single requester.

Test Plan:
- Single event: reset, en_i=1, src_pulse_i=4'b0100 for one cycle, ack_i=1 two cycles after edge_o -> edge_o high exactly 1 cycle, 2 cycles after the pulse, id_o=2, pend_o=0 after the grant, busy_o high for 2+GapCycles cycles.
- Round robin: src_pulse_i=4'b1111 in one cycle, immediate ack -> issue order id_o=0,1,2,3, edge_o pulses 5 cycles apart (GapCycles=2), ovf_o=0.
- Overflow: pulse source 1 twice while en_i=0 -> ovf_o=4'b0010, pend_o=4'b0010. Assert ovf_clr_i[1] -> ovf_o=0. Set-wins check: clear and overflowing pulse in the same cycle -> ovf_o[1]=1.
- Timeout: AckTimeout=16, one event, ack_i held 0 -> timeout_o rises 16 cycles after entering WAIT_ACK, then GAP, then IDLE. Next event still issues. ack_i on exactly the 16th cycle -> timeout_o stays 0.
- Same-cycle capture: pend[3]=1, src_pulse_i[3] pulses on its grant cycle -> pend_o[3] stays 1, ovf_o[3]=0, source 3 issued again after the other pending sources.
- Reset mid-event: rst_i asserted during WAIT_ACK with pend_o=4'b1010 -> edge_o=0, busy_o=0, pend_o=0, id_o=0 without waiting for a clock edge. After release, the first grant goes to the lowest set source index.
